// File: rtl/rdoq_pkg.sv
// rdoq_pkg: shared scale table, widths, types and clip bounds for the RDOQ quant/dequant datapaths
package rdoq_pkg;
  localparam int IQUANT_SHIFT = 6;
  localparam int COEF_W = 16;
  localparam int CNT_W = 11;
  localparam logic [6:0] INV_QUANT_SCALE [6] = '{7'd40, 7'd45, 7'd51, 7'd57, 7'd64, 7'd72};
  typedef logic signed [COEF_W-1:0] coef_t;
  typedef enum logic {IDLE, RUN} dq_state_e;
  localparam coef_t COEF_MIN = 16'sh8000;
  localparam coef_t COEF_MAX = 16'sh7fff;
endpackage

// File: rtl/rdoq_round_shift.sv
// rdoq_round_shift: rounding arithmetic right shift (s>0), pass-through (s=0) or left shift (s<0) of a scaled level
// Ports: p_i scaled level, s_i signed shift, r_o 48-bit signed result
module rdoq_round_shift (
  input  logic signed [23:0] p_i,
  input  logic signed [5:0]  s_i,
  output logic signed [47:0] r_o
);
  logic signed [47:0] p_x, rnd;
  logic [5:0] rs, ls;
  always_comb begin
    p_x = {{24{p_i[23]}}, p_i};
    rs = s_i;
    ls = 6'(-s_i);
    rnd = 48'sd1 <<< (rs - 6'd1);
    // 48 bits keep the largest left shift (level*scale << 17) exact before clipping
    r_o = s_i[5] ? p_x <<< ls : (rs == 6'd0 ? p_x : (p_x + rnd) >>> rs);
  end
endmodule

// File: rtl/rdoq_dequant_pipe.sv
// rdoq_dequant_pipe: 3-stage inverse-quant pipeline (scale, round/shift, clip) with per-block nonzero count
// Ports: cfg_* block config handshake (qp_per, qp_rem, tr_shift); in_* level stream with last;
//        out_* clipped coefficient stream with last and nonzero count (valid on last beat)
module rdoq_dequant_pipe
  import rdoq_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_valid_i,
  output logic                     cfg_ready_o,
  input  logic [3:0]               cfg_qp_per_i,
  input  logic [2:0]               cfg_qp_rem_i,
  input  logic [4:0]               cfg_tr_shift_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic signed [COEF_W-1:0] in_level_i,
  input  logic                     in_last_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic signed [COEF_W-1:0] out_coef_o,
  output logic                     out_last_o,
  output logic [CNT_W-1:0]         out_nz_cnt_o
);
  dq_state_e state_q, state_d;
  logic [6:0] scale_q, scale_d;
  logic signed [5:0] s_q, s_d;
  logic adv, cfg_fire, in_fire;
  logic [3:0] tr_c;
  logic signed [23:0] prod;
  logic v1_q, last1_q, z1_q;
  logic signed [23:0] p1_q;
  logic signed [5:0] s1_q;
  logic v2_q, last2_q;
  logic signed [47:0] r2_q, r_shift;
  coef_t clip;
  logic [CNT_W-1:0] run_q, total;
  logic out_valid_q, out_last_q;
  coef_t out_coef_q;
  logic [CNT_W-1:0] out_nz_cnt_q;
  rdoq_round_shift u_rs (.p_i(p1_q), .s_i(s1_q), .r_o(r_shift));
  always_comb begin
    adv = !out_valid_q || out_ready_i;
    cfg_ready_o = rst_n && state_q == IDLE;
    in_ready_o = state_q == RUN && adv;
    cfg_fire = cfg_valid_i && cfg_ready_o;
    in_fire = in_valid_i && in_ready_o;
    state_d = cfg_fire ? RUN : (in_fire && in_last_i) ? IDLE : state_q;
    tr_c = cfg_tr_shift_i[4] ? 4'd15 : cfg_tr_shift_i[3:0];
    scale_d = cfg_fire ? INV_QUANT_SCALE[cfg_qp_rem_i > 3'd5 ? 3'd0 : cfg_qp_rem_i] : scale_q;
    // 6-bit wrap-around subtraction yields the two's-complement shift directly
    s_d = cfg_fire ? signed'(6'(IQUANT_SHIFT) - {2'b00, tr_c} - {2'b00, cfg_qp_per_i}) : s_q;
    prod = 24'(in_level_i) * 24'(signed'({1'b0, scale_q}));
    clip = r2_q > 48'(COEF_MAX) ? COEF_MAX : r2_q < 48'(COEF_MIN) ? COEF_MIN : coef_t'(r2_q[15:0]);
    total = (run_q == '1 || clip == '0) ? run_q : run_q + CNT_W'(1);
    out_valid_o = out_valid_q;
    out_coef_o = out_coef_q;
    out_last_o = out_last_q;
    out_nz_cnt_o = out_nz_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      scale_q <= '0;
      s_q <= '0;
      v1_q <= 1'b0;
      p1_q <= '0;
      s1_q <= '0;
      last1_q <= 1'b0;
      z1_q <= 1'b0;
      v2_q <= 1'b0;
      r2_q <= '0;
      last2_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_coef_q <= '0;
      out_last_q <= 1'b0;
      out_nz_cnt_q <= '0;
      run_q <= '0;
    end else begin
      state_q <= state_d;
      scale_q <= scale_d;
      s_q <= s_d;
      if (adv) begin
        v1_q <= in_fire;
        p1_q <= prod;
        s1_q <= s_q;
        last1_q <= in_fire && in_last_i;
        z1_q <= in_level_i == '0;
        v2_q <= v1_q;
        r2_q <= z1_q ? '0 : r_shift;
        last2_q <= v1_q && last1_q;
        out_valid_q <= v2_q;
        out_last_q <= v2_q && last2_q;
        // count is shown only with the last beat and drops to zero once that beat is taken
        out_nz_cnt_q <= (v2_q && last2_q) ? total : '0;
        if (v2_q) begin
          out_coef_q <= clip;
          run_q <= last2_q ? '0 : total;
        end
      end
    end
  end
endmodule

// File: tb/tb_rdoq_dequant_pipe.sv
// tb_rdoq_dequant_pipe: directed scoreboard bench for the inverse-quant pipeline
module tb_rdoq_dequant_pipe;
  import rdoq_pkg::*;
  typedef struct packed {
    logic [15:0] c;
    logic l;
    logic [10:0] n;
  } exp_t;
  logic clk = 0, rst_n = 0;
  logic cfg_valid = 0, cfg_ready;
  logic [3:0] cfg_qp_per = 0;
  logic [2:0] cfg_qp_rem = 0;
  logic [4:0] cfg_tr_shift = 0;
  logic in_valid = 0, in_ready, in_last = 0;
  logic signed [15:0] in_level = 0;
  logic out_valid, out_ready = 1, out_last;
  logic signed [15:0] out_coef;
  logic [10:0] out_nz_cnt;
  exp_t q[$];
  exp_t e;
  int checks = 0, passed = 0, blk_nz = 0, ph = 0;
  bit bp_en = 0;
  bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  bit stall_p = 0;
  logic signed [15:0] hc;
  logic hl;
  logic [10:0] hn;

  rdoq_dequant_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
    .cfg_qp_per_i(cfg_qp_per), .cfg_qp_rem_i(cfg_qp_rem), .cfg_tr_shift_i(cfg_tr_shift),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_level_i(in_level), .in_last_i(in_last),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_coef_o(out_coef),
    .out_last_o(out_last), .out_nz_cnt_o(out_nz_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) begin
        out_ready = pat[ph];
        ph = (ph + 1) % 4;
      end else out_ready = 1;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) stall_p = 0;
    else begin
      if (stall_p) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_coef", out_coef, hc);
        chk("hold_last", out_last, hl);
        chk("hold_nz", out_nz_cnt, hn);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("unexpected_output", 1, 0);
        else begin
          e = q.pop_front();
          chk("coef", out_coef, $signed(e.c));
          chk("last", out_last, e.l);
          if (e.l) chk("nz_cnt", out_nz_cnt, e.n);
        end
      end
      stall_p = out_valid && !out_ready;
      hc = out_coef;
      hl = out_last;
      hn = out_nz_cnt;
    end
  end

  task automatic cfg(input int per, input int rem, input int tr);
    int n = 0;
    in_valid = 0;
    cfg_valid = 1;
    cfg_qp_per = 4'(per);
    cfg_qp_rem = 3'(rem);
    cfg_tr_shift = 5'(tr);
    while (!cfg_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cfg_ready) chk("cfg_ready_timeout", 0, 1);
    @(negedge clk);
    cfg_valid = 0;
  endtask

  task automatic send(input int lv, input bit last, input int ec);
    int n = 0;
    in_valid = 1;
    in_level = 16'(lv);
    in_last = last;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    else begin
      if (ec != 0) blk_nz++;
      q.push_back('{c: 16'(ec), l: last, n: 11'(last ? blk_nz : 0)});
      if (last) blk_nz = 0;
    end
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_coef", out_coef, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_nz_cnt", out_nz_cnt, 0);
    rst_n = 1;
    @(negedge clk);
    chk("idle_cfg_ready", cfg_ready, 1);
    chk("idle_in_ready", in_ready, 0);
    in_valid = 1;
    in_level = 7;
    in_last = 1;
    repeat (2) @(negedge clk);
    chk("idle_ignores_in", in_ready, 0);
    cfg(0, 0, 5);
    send(3, 0, 60);
    send(-3, 0, -60);
    send(0, 1, 0);
    chk("b2b_cfg_ready", cfg_ready, 1);
    chk("b2b_in_ready", in_ready, 0);
    cfg(0, 1, 5);
    send(2, 0, 45);
    send(1, 0, 23);
    send(-1, 1, -22);
    cfg(0, 4, 0);
    send(1, 0, 1);
    send(-1, 0, -1);
    send(2, 1, 2);
    cfg(4, 5, 5);
    send(10, 0, 5760);
    send(100, 0, 32767);
    send(-1000, 1, -32768);
    cfg(8, 5, 31);
    send(32767, 1, 32767);
    cfg(0, 7, 5);
    send(3, 1, 60);
    cfg(0, 0, 5);
    send(0, 1, 0);
    drain();
    bp_en = 1;
    cfg(0, 0, 5);
    for (int i = 1; i <= 16; i++) send(i % 2 ? i : -i, i == 16, i % 2 ? 20 * i : -20 * i);
    drain();
    bp_en = 0;
    cfg(0, 0, 5);
    in_valid = 1;
    in_level = 9;
    in_last = 0;
    repeat (2) @(negedge clk);
    rst_n = 0;
    in_valid = 0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_cfg_ready", cfg_ready, 0);
    repeat (3) @(negedge clk);
    chk("midrst_out_valid_hold", out_valid, 0);
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_cfg_ready", cfg_ready, 1);
    chk("post_rst_in_ready", in_ready, 0);
    chk("post_rst_out_valid", out_valid, 0);
    cfg(0, 0, 5);
    send(5, 0, 100);
    send(-5, 1, -100);
    drain();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
